// File: rtl/multi_clk_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package multi_clk_divider_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_clk_divider_if.sv
// Configuration port of the divider: valid/ready request plus status back to the requester.
interface multi_clk_divider_if
    import multi_clk_divider_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int W      = 32
);

    localparam int CH_W = ch_width(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [W-1:0]      cfg_div;
    logic              cfg_mode;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_pend;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_mode,
        input  cfg_ready, cfg_err, cfg_pend
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
        output cfg_ready, cfg_err, cfg_pend
    );

endinterface

// File: rtl/multi_clk_divider_channel.sv
// One divider channel: period counter, active divisor/mode and a single-entry pending update.
module multi_clk_divider_channel
    import multi_clk_divider_pkg::*;
#(
    parameter int          W           = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000
)
(
    input  logic         click,
    input  logic         rst,
    input  logic         en,
    input  logic         ld_stb,
    input  logic [W-1:0] ld_div,
    input  logic         ld_mode,
    output logic         pend,
    output logic         clk_N,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic         mode_q, mode_d;
    logic         pend_q, pend_d;
    logic         clk_n_q, clk_n_d;
    logic         tick_q, tick_d;
    logic [W-1:0] div_pend_q, div_pend_d;
    logic         mode_pend_q, mode_pend_d;

    logic running;
    logic terminal;

    assign running  = en && (div_q != '0);
    assign terminal = running && (cnt_q == div_q - W'(1));

    // Next-state: count, fire terminal events, swap in a pending update when it is safe.
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        clk_n_d     = clk_n_q;
        tick_d      = 1'b0;
        div_pend_d  = div_pend_q;
        mode_pend_d = mode_pend_q;

        if (running) begin
            if (terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (mode_q == MODE_TOGGLE) begin
                    clk_n_d = ~clk_n_q;
                end
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (div_q == '0) begin
            cnt_d = '0;
        end

        // A stopped channel has no period boundary to wait for, so it takes the update at once.
        if (pend_q && (terminal || !running)) begin
            div_d  = div_pend_q;
            mode_d = mode_pend_q;
            pend_d = 1'b0;
            cnt_d  = '0;
            if (mode_pend_q == MODE_PULSE) begin
                clk_n_d = 1'b0;
            end
        end

        // The top only strobes a load while nothing is pending, so this never races the swap above.
        if (ld_stb) begin
            pend_d      = 1'b1;
            div_pend_d  = ld_div;
            mode_pend_d = ld_mode;
        end
    end

    // Control and active-configuration registers, cleared by reset.
    always_ff @(posedge click) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= W'(DEFAULT_DIV);
            mode_q  <= MODE_TOGGLE;
            pend_q  <= 1'b0;
            clk_n_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            clk_n_q <= clk_n_d;
            tick_q  <= tick_d;
        end
    end

    // Pending payload; only meaningful while pend_q is set, so it needs no reset.
    always_ff @(posedge click) begin
        div_pend_q  <= div_pend_d;
        mode_pend_q <= mode_pend_d;
    end

    assign pend  = pend_q;
    assign clk_N = clk_n_q;
    assign tick  = tick_q;

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH independent clock dividers / tick generators sharing one configuration port.
module multi_clk_divider
    import multi_clk_divider_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          W           = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000
)
(
    input  logic              click,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    multi_clk_divider_if.slave cfg,
    output logic [NUM_CH-1:0] clk_N,
    output logic [NUM_CH-1:0] tick
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [CH_W-1:0]   ch_sel;
    logic              ch_in_range;
    logic              xfer;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ld_stb;
    logic              cfg_err_q, cfg_err_d;

    assign ch_sel      = cfg.cfg_ch;
    assign ch_in_range = (32'(ch_sel) < 32'(NUM_CH));
    assign xfer        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_err_d   = xfer && !ch_in_range;

    // Ready mux: a channel accepts only when its pending slot is free; bad indices are always accepted.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(ch_sel) == 32'(i)) begin
                cfg.cfg_ready = ~pend[i];
            end
        end
    end

    // One-cycle error flag for a dropped out-of-range request.
    always_ff @(posedge click) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg.cfg_err  = cfg_err_q;
    assign cfg.cfg_pend = pend;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ld_stb[g] = xfer && (32'(ch_sel) == 32'(g));

        multi_clk_divider_channel #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .click   (click),
            .rst     (rst),
            .en      (en[g]),
            .ld_stb  (ld_stb[g]),
            .ld_div  (cfg.cfg_div),
            .ld_mode (cfg.cfg_mode),
            .pend    (pend[g]),
            .clk_N   (clk_N[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider. Three channels so that a 2-bit cfg_ch can name a
// non-existent channel (index 3); reset divisor shortened to 5.
module tb_multi_clk_divider;

    localparam int NUM_CH = 3;
    localparam int W      = 32;

    logic              click;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] clk_N;
    logic [NUM_CH-1:0] tick;

    multi_clk_divider_if #(.NUM_CH(NUM_CH), .W(W)) cfg_if ();

    multi_clk_divider #(
        .NUM_CH      (NUM_CH),
        .W           (W),
        .DEFAULT_DIV (5)
    ) dut (
        .click (click),
        .rst   (rst),
        .en    (en),
        .cfg   (cfg_if.slave),
        .clk_N (clk_N),
        .tick  (tick)
    );

    initial click = 1'b0;
    always #5 click = ~click;

    typedef struct {
        string      tag;
        logic [2:0] tick;
        logic [2:0] clkn;
        logic [2:0] pend;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [2:0] ec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Queue the expected outputs for the coming edge, clock, then compare what came out.
    task automatic cyc(input string tag, input logic [2:0] t, input logic [2:0] c,
                       input logic [2:0] p, input logic e);
        exp_t x;
        x.tag = tag; x.tick = t; x.clkn = c; x.pend = p; x.err = e;
        sb.push_back(x);
        @(posedge click);
        #1;
        x = sb.pop_front();
        chk({x.tag, ".tick"}, 32'(tick), 32'(x.tick));
        chk({x.tag, ".clk_N"}, 32'(clk_N), 32'(x.clkn));
        chk({x.tag, ".pend"}, 32'(cfg_if.cfg_pend), 32'(x.pend));
        chk({x.tag, ".err"}, 32'(cfg_if.cfg_err), 32'(x.err));
    endtask

    initial begin
        logic t;
        logic p;

        rst = 1'b1;
        en  = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_mode  = 1'b0;
        ec = '0;

        // Reset state
        @(posedge click); #1;
        cyc("rst", 3'b000, 3'b000, 3'b000, 1'b0);
        chk("rst.ready", 32'(cfg_if.cfg_ready), 32'd1);

        // Test 1: ch0 at the default divisor of 5
        rst = 1'b0;
        en  = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            t = (k % 5 == 0);
            if (t) ec[0] = ~ec[0];
            cyc("t1", {2'b00, t}, ec, 3'b000, 1'b0);
        end

        // Test 6a: disable ch0 at cnt=2 for 10 cycles; resume without restart
        cyc("t6run", 3'b000, ec, 3'b000, 1'b0);
        cyc("t6run", 3'b000, ec, 3'b000, 1'b0);
        en = 3'b000;
        for (int k = 0; k < 10; k++) cyc("t6hold", 3'b000, ec, 3'b000, 1'b0);
        en = 3'b001;
        cyc("t6re1", 3'b000, ec, 3'b000, 1'b0);
        cyc("t6re2", 3'b000, ec, 3'b000, 1'b0);
        ec[0] = 1'b1;
        cyc("t6re3", 3'b001, ec, 3'b000, 1'b0);
        en = 3'b000;

        // Test 2/3: ch1 D=3, retarget to 7 mid-period, then a stalled second write
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_div   = 32'd3;
        cfg_if.cfg_mode  = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        chk("t2.ready0", 32'(cfg_if.cfg_ready), 32'd1);
        cyc("t2ld", 3'b000, ec, 3'b010, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        cyc("t2apply", 3'b000, ec, 3'b000, 1'b0);
        en = 3'b010;
        for (int k = 1; k <= 21; k++) begin
            if (k == 5)  begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 32'd7; end
            if (k == 6)  cfg_if.cfg_valid = 1'b0;
            if (k == 8)  begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 32'd4; end
            if (k == 9)  cfg_if.cfg_div = 32'd2;
            if (k == 15) cfg_if.cfg_valid = 1'b0;
            t = (k == 3) || (k == 6) || (k == 13) || (k == 17) || (k == 19) || (k == 21);
            p = (k == 5) || (k >= 8 && k <= 12) || (k >= 14 && k <= 16);
            if (t) ec[1] = ~ec[1];
            cyc("t23", {1'b0, t, 1'b0}, ec, {1'b0, p, 1'b0}, 1'b0);
            chk("t23.ready", 32'(cfg_if.cfg_ready), 32'(!p));
        end
        en = 3'b000;

        // Test 4: ch2 D=1 pulse mode, then D=0
        cfg_if.cfg_ch    = 2'd2;
        cfg_if.cfg_div   = 32'd1;
        cfg_if.cfg_mode  = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cyc("t4ld", 3'b000, ec, 3'b100, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        cyc("t4apply", 3'b000, ec, 3'b000, 1'b0);
        en = 3'b100;
        for (int k = 0; k < 5; k++) cyc("t4d1", 3'b100, ec, 3'b000, 1'b0);
        cfg_if.cfg_div   = 32'd0;
        cfg_if.cfg_valid = 1'b1;
        cyc("t4ld0", 3'b100, ec, 3'b100, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        cyc("t4app0", 3'b100, ec, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) cyc("t4idle", 3'b000, ec, 3'b000, 1'b0);
        en = 3'b000;

        // Test 5: out-of-range channel index
        cfg_if.cfg_ch    = 2'd3;
        cfg_if.cfg_div   = 32'd9;
        cfg_if.cfg_mode  = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        chk("t5.ready", 32'(cfg_if.cfg_ready), 32'd1);
        cyc("t5err", 3'b000, ec, 3'b000, 1'b1);
        cfg_if.cfg_valid = 1'b0;
        cyc("t5clr", 3'b000, ec, 3'b000, 1'b0);

        // Test 6b: reset mid-period with an update pending on ch0
        en = 3'b001;
        cyc("t7run", 3'b000, ec, 3'b000, 1'b0);
        cyc("t7run", 3'b000, ec, 3'b000, 1'b0);
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 32'd9;
        cfg_if.cfg_valid = 1'b1;
        cyc("t7ld", 3'b000, ec, 3'b001, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b1;
        ec  = 3'b000;
        cyc("t7rst", 3'b000, ec, 3'b000, 1'b0);
        chk("t7.ready", 32'(cfg_if.cfg_ready), 32'd1);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            t = (k == 5);
            if (t) ec[0] = ~ec[0];
            cyc("t7post", {2'b00, t}, ec, 3'b000, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
